// File: rtl/ecpa.sv
`default_nettype none
// ============================================================================
//  Module   : ecpa
//  Purpose  : Elliptic-curve point adder in homogeneous projective coordinates
//             over GF(p), 256-bit. One bit-serial modular multiplier and one
//             modular add/sub unit are sequenced by a fixed 21-step microcode.
//  Revision : 1.0  initial release
// ============================================================================
module ecpa (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [255:0] p,
    input  logic [255:0] X1,
    input  logic [255:0] Y1,
    input  logic [255:0] Z1,
    input  logic [255:0] X2,
    input  logic [255:0] Y2,
    input  logic [255:0] Z2,
    output logic [255:0] X3,
    output logic [255:0] Y3,
    output logic [255:0] Z3,
    output logic         o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    // Register-file slots; codes above R_TMP address the output registers.
    localparam logic [4:0] R_X1  = 5'd0;
    localparam logic [4:0] R_Y1  = 5'd1;
    localparam logic [4:0] R_Z1  = 5'd2;
    localparam logic [4:0] R_X2  = 5'd3;
    localparam logic [4:0] R_Y2  = 5'd4;
    localparam logic [4:0] R_Z2  = 5'd5;
    localparam logic [4:0] R_T1  = 5'd6;
    localparam logic [4:0] R_T2  = 5'd7;
    localparam logic [4:0] R_U   = 5'd8;
    localparam logic [4:0] R_T3  = 5'd9;
    localparam logic [4:0] R_T4  = 5'd10;
    localparam logic [4:0] R_V   = 5'd11;
    localparam logic [4:0] R_UU  = 5'd12;
    localparam logic [4:0] R_ZZ  = 5'd13;
    localparam logic [4:0] R_VV  = 5'd14;
    localparam logic [4:0] R_VVV = 5'd15;
    localparam logic [4:0] R_R   = 5'd16;
    localparam logic [4:0] R_W   = 5'd17;
    localparam logic [4:0] R_TMP = 5'd18;
    localparam logic [4:0] R_X3  = 5'd19;
    localparam logic [4:0] R_Y3  = 5'd20;
    localparam logic [4:0] R_Z3  = 5'd21;

    localparam logic [4:0] LAST_STEP = 5'd20;

    // Microcode word: {op, src_a, src_b, dst}
    function automatic logic [16:0] ucode(input logic [4:0] s);
        case (s)
            5'd0:    ucode = {OP_MUL, R_Y2,  R_Z1,  R_T1 };  // t1 = Y2*Z1
            5'd1:    ucode = {OP_MUL, R_Y1,  R_Z2,  R_T2 };  // t2 = Y1*Z2
            5'd2:    ucode = {OP_SUB, R_T1,  R_T2,  R_U  };  // u  = t1-t2
            5'd3:    ucode = {OP_MUL, R_X2,  R_Z1,  R_T3 };  // t3 = X2*Z1
            5'd4:    ucode = {OP_MUL, R_X1,  R_Z2,  R_T4 };  // t4 = X1*Z2
            5'd5:    ucode = {OP_SUB, R_T3,  R_T4,  R_V  };  // v  = t3-t4
            5'd6:    ucode = {OP_MUL, R_U,   R_U,   R_UU };  // uu = u^2
            5'd7:    ucode = {OP_MUL, R_Z1,  R_Z2,  R_ZZ };  // zz = Z1*Z2
            5'd8:    ucode = {OP_MUL, R_V,   R_V,   R_VV };  // vv = v^2
            5'd9:    ucode = {OP_MUL, R_VV,  R_V,   R_VVV};  // vvv = vv*v
            5'd10:   ucode = {OP_MUL, R_VV,  R_T4,  R_R  };  // r  = vv*t4
            5'd11:   ucode = {OP_MUL, R_UU,  R_ZZ,  R_W  };  // w  = uu*zz
            5'd12:   ucode = {OP_SUB, R_W,   R_VVV, R_W  };  // w -= vvv
            5'd13:   ucode = {OP_ADD, R_R,   R_R,   R_TMP};  // tmp = 2r
            5'd14:   ucode = {OP_SUB, R_W,   R_TMP, R_W  };  // w -= 2r
            5'd15:   ucode = {OP_MUL, R_V,   R_W,   R_X3 };  // X3 = v*w
            5'd16:   ucode = {OP_SUB, R_R,   R_W,   R_TMP};  // tmp = r-w
            5'd17:   ucode = {OP_MUL, R_U,   R_TMP, R_TMP};  // tmp = u*(r-w)
            5'd18:   ucode = {OP_MUL, R_VVV, R_T2,  R_T1 };  // t1 = vvv*t2
            5'd19:   ucode = {OP_SUB, R_TMP, R_T1,  R_Y3 };  // Y3
            5'd20:   ucode = {OP_MUL, R_VVV, R_ZZ,  R_Z3 };  // Z3 = vvv*zz
            default: ucode = {OP_SUB, R_X1,  R_X1,  R_TMP};
        endcase
    endfunction

    logic [1:0]   state;
    logic [4:0]   step;
    logic         mul_run;     // 0: setup cycle pending, 1: iterating
    logic [7:0]   bit_cnt;
    logic [255:0] regs [0:18];
    logic [255:0] pr;
    logic [255:0] mul_a;
    logic [255:0] mul_b;
    logic [257:0] acc;

    logic [16:0]  uc;
    logic [1:0]   op;
    logic [4:0]   src_a;
    logic [4:0]   src_b;
    logic [4:0]   dst;
    logic [255:0] opa;
    logic [255:0] opb;
    logic [257:0] pz;
    logic [257:0] acc_dbl;
    logic [257:0] red1;
    logic [257:0] red2;
    logic [256:0] pe;
    logic [256:0] sum;
    logic [256:0] diff;
    logic [255:0] as_res;
    logic [255:0] wr_val;
    logic         wr_en;

    // Microcode decode plus multiplier-step and add/sub datapaths
    always_comb begin
        uc     = ucode(step);
        op     = uc[16:15];
        src_a  = uc[14:10];
        src_b  = uc[9:5];
        dst    = uc[4:0];
        opa    = regs[src_a];
        opb    = regs[src_b];

        // acc < p, so 2*acc + a < 3p: two conditional subtractions suffice
        pz      = {2'b00, pr};
        acc_dbl = (acc << 1) + (mul_b[255] ? {2'b00, mul_a} : 258'd0);
        red1    = (acc_dbl >= pz) ? (acc_dbl - pz) : acc_dbl;
        red2    = (red1 >= pz) ? (red1 - pz) : red1;

        pe   = {1'b0, pr};
        sum  = {1'b0, opa} + {1'b0, opb};
        diff = {1'b0, opa} - {1'b0, opb};
        if (op == OP_ADD) begin
            as_res = (sum >= pe) ? 256'(sum - pe) : sum[255:0];
        end else begin
            as_res = diff[256] ? 256'(diff + pe) : diff[255:0];
        end

        wr_en  = (state == ST_BUSY) &&
                 ((op != OP_MUL) || (mul_run && (bit_cnt == 8'd0)));
        wr_val = (op == OP_MUL) ? red2[255:0] : as_res;
    end

    // Operand latch, working registers and multiplier datapath (no reset needed)
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && i_start) begin
            pr         <= p;
            regs[R_X1] <= X1;
            regs[R_Y1] <= Y1;
            regs[R_Z1] <= Z1;
            regs[R_X2] <= X2;
            regs[R_Y2] <= Y2;
            regs[R_Z2] <= Z2;
        end
        if (state == ST_BUSY && op == OP_MUL) begin
            if (!mul_run) begin
                mul_a <= opa;
                mul_b <= opb;
                acc   <= '0;
            end else begin
                acc   <= red2;
                mul_b <= mul_b << 1;
            end
        end
        if (wr_en && dst <= R_TMP) begin
            regs[dst] <= wr_val;
        end
    end

    // Control FSM, step sequencing, result registers and handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            step    <= '0;
            mul_run <= 1'b0;
            bit_cnt <= '0;
            o_done  <= 1'b0;
            X3      <= '0;
            Y3      <= '0;
            Z3      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state   <= ST_BUSY;
                        step    <= '0;
                        mul_run <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (op == OP_MUL) begin
                        if (!mul_run) begin
                            mul_run <= 1'b1;
                            bit_cnt <= 8'd255;
                        end else if (bit_cnt != 8'd0) begin
                            bit_cnt <= bit_cnt - 8'd1;
                        end else begin
                            mul_run <= 1'b0;
                        end
                    end
                    if (wr_en) begin
                        if (dst == R_X3) X3 <= wr_val;
                        if (dst == R_Y3) Y3 <= wr_val;
                        if (dst == R_Z3) Z3 <= wr_val;
                        if (step == LAST_STEP) begin
                            state <= ST_DONE;
                        end else begin
                            step <= step + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // First DONE cycle raises o_done; afterwards wait for start low
                    if (!o_done) begin
                        o_done <= 1'b1;
                    end else if (!i_start) begin
                        o_done <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecpa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ecpa
//  Purpose  : Self-checking bench for the ecpa projective point adder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ecpa;

    // 14 multiplies of 257 cycles, 7 add/sub cycles, 1 cycle to raise o_done
    localparam int L_EXP = 14 * 257 + 7 + 1;
    localparam int BOUND = 4000;

    typedef struct {
        logic [255:0] x;
        logic [255:0] y;
        logic [255:0] z;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_start;
    logic [255:0] p, X1, Y1, Z1, X2, Y2, Z2;
    logic [255:0] X3, Y3, Z3;
    logic         o_done;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ecpa dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .p       (p),
        .X1      (X1),
        .Y1      (Y1),
        .Z1      (Z1),
        .X2      (X2),
        .Y2      (Y2),
        .Z2      (Z2),
        .X3      (X3),
        .Y3      (Y3),
        .Z3      (Z3),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    function automatic logic [255:0] mm(input logic [255:0] a, input logic [255:0] b,
                                        input logic [255:0] m);
        logic [511:0] prod;
        prod = {256'd0, a} * {256'd0, b};
        prod = prod % {256'd0, m};
        return prod[255:0];
    endfunction

    function automatic logic [255:0] ms(input logic [255:0] a, input logic [255:0] b,
                                        input logic [255:0] m);
        logic [256:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, a} + {1'b0, m} - {1'b0, b};
        return d[255:0];
    endfunction

    function automatic exp_t model(input logic [255:0] m,
                                   input logic [255:0] x1, input logic [255:0] y1,
                                   input logic [255:0] z1, input logic [255:0] x2,
                                   input logic [255:0] y2, input logic [255:0] z2);
        logic [255:0] t1, t2, u, t3, t4, v, uu, zz, vv, vvv, r, w;
        exp_t e;
        t1  = mm(y2, z1, m);
        t2  = mm(y1, z2, m);
        u   = ms(t1, t2, m);
        t3  = mm(x2, z1, m);
        t4  = mm(x1, z2, m);
        v   = ms(t3, t4, m);
        uu  = mm(u, u, m);
        zz  = mm(z1, z2, m);
        vv  = mm(v, v, m);
        vvv = mm(vv, v, m);
        r   = mm(vv, t4, m);
        w   = ms(ms(ms(mm(uu, zz, m), vvv, m), r, m), r, m);
        e.x = mm(v, w, m);
        e.y = ms(mm(u, ms(r, w, m), m), mm(vvv, t2, m), m);
        e.z = mm(vvv, zz, m);
        return e;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Raise start with the given operands and wait (bounded) for o_done.
    task automatic run_op(input logic [255:0] pp,
                          input logic [255:0] x1, input logic [255:0] y1,
                          input logic [255:0] z1, input logic [255:0] x2,
                          input logic [255:0] y2, input logic [255:0] z2,
                          input int scramble_at, output int lat, output bit tmo);
        p = pp; X1 = x1; Y1 = y1; Z1 = z1; X2 = x2; Y2 = y2; Z2 = z2;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        lat = 0;
        tmo = 1'b0;
        while (!o_done) begin
            if (lat >= BOUND) begin
                tmo = 1'b1;
                break;
            end
            @(posedge i_clk); #1;
            lat++;
            if (scramble_at != 0 && lat == scramble_at) begin
                p  = rand256(); X1 = rand256(); Y1 = rand256(); Z1 = rand256();
                X2 = rand256(); Y2 = rand256(); Z2 = rand256();
            end
        end
    endtask

    task automatic drop_start();
        i_start = 1'b0;
        @(posedge i_clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        p = '0; X1 = '0; Y1 = '0; Z1 = '0; X2 = '0; Y2 = '0; Z2 = '0;
        repeat (3) @(posedge i_clk);
        #1;
        n_cmp++; if (X3 !== 256'd0) begin n_bad++; $display("FAIL reset_X3: got %0h expected 0", X3); end
        n_cmp++; if (Y3 !== 256'd0) begin n_bad++; $display("FAIL reset_Y3: got %0h expected 0", Y3); end
        n_cmp++; if (Z3 !== 256'd0) begin n_bad++; $display("FAIL reset_Z3: got %0h expected 0", Z3); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", o_done); end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic();
        int lat; bit tmo; exp_t e;
        sb.push_back('{x: 256'd5, y: 256'd1, z: 256'd8});
        run_op(256'd23, 256'd5, 256'd17, 256'd1, 256'd7, 256'd13, 256'd1, 0, lat, tmo);
        e = sb.pop_front();
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL basic_timeout: got no done expected done within %0d", BOUND); end
        n_cmp++; if (X3 !== e.x) begin n_bad++; $display("FAIL basic_X3: got %0h expected %0h", X3, e.x); end
        n_cmp++; if (Y3 !== e.y) begin n_bad++; $display("FAIL basic_Y3: got %0h expected %0h", Y3, e.y); end
        n_cmp++; if (Z3 !== e.z) begin n_bad++; $display("FAIL basic_Z3: got %0h expected %0h", Z3, e.z); end
        n_cmp++; if (lat != L_EXP) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", lat, L_EXP); end
    endtask

    // Start stays high after the first result: no retrigger, outputs frozen.
    task automatic test_hold();
        for (int i = 0; i < 100; i++) begin
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_done !== 1'b1 || X3 !== 256'd5 || Y3 !== 256'd1 || Z3 !== 256'd8) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got done=%b X3=%0h Y3=%0h Z3=%0h expected 1/5/1/8",
                         i, o_done, X3, Y3, Z3);
            end
        end
        drop_start();
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %b expected 0", o_done); end
        n_cmp++; if (X3 !== 256'd5) begin n_bad++; $display("FAIL hold_X3_after: got %0h expected 5", X3); end
    endtask

    task automatic test_second();
        int lat; bit tmo; exp_t e;
        sb.push_back('{x: 256'd90, y: 256'd90, z: 256'd50});
        run_op(256'd233, 256'd51, 256'd177, 256'd1, 256'd79, 256'd131, 256'd1, 0, lat, tmo);
        e = sb.pop_front();
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL second_timeout: got no done expected done within %0d", BOUND); end
        n_cmp++; if (X3 !== e.x) begin n_bad++; $display("FAIL second_X3: got %0h expected %0h", X3, e.x); end
        n_cmp++; if (Y3 !== e.y) begin n_bad++; $display("FAIL second_Y3: got %0h expected %0h", Y3, e.y); end
        n_cmp++; if (Z3 !== e.z) begin n_bad++; $display("FAIL second_Z3: got %0h expected %0h", Z3, e.z); end
        n_cmp++; if (lat != L_EXP) begin n_bad++; $display("FAIL second_latency: got %0d expected %0d", lat, L_EXP); end
        drop_start();
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL second_release: got %b expected 0", o_done); end
    endtask

    task automatic test_equal();
        int lat; bit tmo; exp_t e;
        sb.push_back('{x: 256'd0, y: 256'd0, z: 256'd0});
        run_op(256'd23, 256'd5, 256'd17, 256'd1, 256'd5, 256'd17, 256'd1, 0, lat, tmo);
        e = sb.pop_front();
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL equal_timeout: got no done expected done within %0d", BOUND); end
        n_cmp++; if (X3 !== e.x || Y3 !== e.y || Z3 !== e.z) begin
            n_bad++; $display("FAIL equal_xyz: got %0h/%0h/%0h expected 0/0/0", X3, Y3, Z3);
        end
        drop_start();
    endtask

    // Operands change mid-operation; the result must reflect the latched values.
    task automatic test_change_busy();
        int lat; bit tmo; exp_t e;
        sb.push_back('{x: 256'd90, y: 256'd90, z: 256'd50});
        run_op(256'd233, 256'd51, 256'd177, 256'd1, 256'd79, 256'd131, 256'd1, 1000, lat, tmo);
        e = sb.pop_front();
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL change_timeout: got no done expected done within %0d", BOUND); end
        n_cmp++; if (X3 !== e.x || Y3 !== e.y || Z3 !== e.z) begin
            n_bad++; $display("FAIL change_xyz: got %0h/%0h/%0h expected %0h/%0h/%0h", X3, Y3, Z3, e.x, e.y, e.z);
        end
        n_cmp++; if (lat != L_EXP) begin n_bad++; $display("FAIL change_latency: got %0d expected %0d", lat, L_EXP); end
        drop_start();
    endtask

    // Asynchronous reset in the middle of BUSY, then a clean full operation.
    task automatic test_mid_reset();
        int lat; bit tmo; exp_t e;
        p = 256'd23; X1 = 256'd5; Y1 = 256'd17; Z1 = 256'd1; X2 = 256'd7; Y2 = 256'd13; Z2 = 256'd1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        repeat (500) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (X3 !== 256'd0 || Y3 !== 256'd0 || Z3 !== 256'd0) begin
            n_bad++; $display("FAIL midreset_xyz: got %0h/%0h/%0h expected 0/0/0", X3, Y3, Z3);
        end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: got %b expected 0", o_done); end
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL midreset_idle%0d: got %b expected 0", i, o_done); end
        end
        sb.push_back('{x: 256'd5, y: 256'd1, z: 256'd8});
        run_op(256'd23, 256'd5, 256'd17, 256'd1, 256'd7, 256'd13, 256'd1, 0, lat, tmo);
        e = sb.pop_front();
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL midreset_timeout: got no done expected done within %0d", BOUND); end
        n_cmp++; if (X3 !== e.x || Y3 !== e.y || Z3 !== e.z) begin
            n_bad++; $display("FAIL midreset_xyz2: got %0h/%0h/%0h expected %0h/%0h/%0h", X3, Y3, Z3, e.x, e.y, e.z);
        end
        n_cmp++; if (lat != L_EXP) begin n_bad++; $display("FAIL midreset_latency: got %0d expected %0d", lat, L_EXP); end
        drop_start();
    endtask

    task automatic test_random();
        int lat; bit tmo; exp_t e;
        logic [255:0] m, a1, b1, c1, a2, b2, c2;
        for (int k = 0; k < 4; k++) begin
            m = rand256();
            m[0] = 1'b1;
            if (k == 0) m[255] = 1'b1;
            if (k == 3) m = m >> 200;
            if (m < 256'd3) m = 256'd3;
            a1 = rand256() % m; b1 = rand256() % m; c1 = rand256() % m;
            a2 = rand256() % m; b2 = rand256() % m; c2 = rand256() % m;
            sb.push_back(model(m, a1, b1, c1, a2, b2, c2));
            run_op(m, a1, b1, c1, a2, b2, c2, 0, lat, tmo);
            e = sb.pop_front();
            n_cmp++; if (tmo) begin n_bad++; $display("FAIL rand%0d_timeout: got no done expected done within %0d", k, BOUND); end
            n_cmp++; if (X3 !== e.x) begin n_bad++; $display("FAIL rand%0d_X3: got %0h expected %0h", k, X3, e.x); end
            n_cmp++; if (Y3 !== e.y) begin n_bad++; $display("FAIL rand%0d_Y3: got %0h expected %0h", k, Y3, e.y); end
            n_cmp++; if (Z3 !== e.z) begin n_bad++; $display("FAIL rand%0d_Z3: got %0h expected %0h", k, Z3, e.z); end
            n_cmp++; if (lat != L_EXP) begin n_bad++; $display("FAIL rand%0d_latency: got %0d expected %0d", k, lat, L_EXP); end
            drop_start();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_second();
        test_equal();
        test_change_busy();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
